// File: rtl/hdlc_bus_scheduler_pkg.sv
// Shared register map, status bit masks and scheduler state encoding for hdlc_bus_scheduler.
// HDLC_SCHED_FCS_EN adds the INIT state that programs FCSen once after reset.
package hdlc_pkg;

   localparam logic [2:0] ADDR_TX_SC   = 3'd0;
   localparam logic [2:0] ADDR_TX_BUFF = 3'd1;
   localparam logic [2:0] ADDR_RX_SC   = 3'd2;
   localparam logic [2:0] ADDR_RX_BUFF = 3'd3;
   localparam logic [2:0] ADDR_RX_LEN  = 3'd4;

   localparam logic [7:0] RX_ERR_MASK = 8'h1C;
   localparam logic [7:0] TX_ENABLE   = 8'h02;
   localparam logic [7:0] RX_DROP     = 8'h02;
   localparam logic [7:0] RX_FCSEN    = 8'h20;

   typedef enum logic [3:0] {
`ifdef HDLC_SCHED_FCS_EN
      ST_INIT,
`endif
      ST_IDLE,
      ST_TX_ACC,
      ST_TX_PUT,
      ST_TX_GO,
      ST_RX_STAT,
      ST_RX_STATC,
      ST_RX_LEN,
      ST_RX_LENC,
      ST_RX_RD,
      ST_RX_CAP,
      ST_RX_OUT,
      ST_RX_DROP
   } sched_state_t;

endpackage

// File: rtl/hdlc_bus_scheduler_rr_arbiter.sv
// Two-requester round-robin arbiter (TX vs RX); the priority pointer moves only when a grant is taken.
module hdlc_rr_arbiter (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic en,
   input  logic req_tx,
   input  logic req_rx,
   output logic gnt_tx,
   output logic gnt_rx
);

   logic prio_rx;

   always_comb begin
      gnt_tx = 1'b0;
      gnt_rx = 1'b0;
      if (en) begin
         if (req_tx && req_rx) begin
            gnt_rx = prio_rx;
            gnt_tx = !prio_rx;
         end else begin
            gnt_tx = req_tx;
            gnt_rx = req_rx;
         end
      end
   end

   // after a TX grant RX owns the next tie, and vice versa
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b)
         prio_rx <= 1'b0;
      else if (gnt_tx || gnt_rx)
         prio_rx <= gnt_tx;
   end

endmodule

// File: rtl/hdlc_bus_scheduler.sv
// Sole master of the Hdlc register bus: loads/enables TX frames and drains or drops RX frames.
// HDLC_SCHED_FCS_EN: write FCSen to Rx_SC once after reset and keep it set on frame drops.
module hdlc_bus_scheduler
   import hdlc_pkg::*;
#(
   parameter int MAX_TX_BYTES = 126,
   parameter int ADDR_W       = 3,
   parameter int DATA_W       = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   output logic [ADDR_W-1:0] Address,
   output logic              WriteEnable,
   output logic              ReadEnable,
   output logic [DATA_W-1:0] DataIn,
   input  logic [DATA_W-1:0] DataOut,
   input  logic              Rx_Ready,
   input  logic              Tx_Done,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_last,
   output logic              tx_ready,
   output logic              tx_trunc,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_last,
   input  logic              rx_ready,
   output logic              rx_err,
   output logic [DATA_W-1:0] rx_status
);

   // state      | meaning
   // INIT       | write FCSen to Rx_SC once (FCS build only)
   // IDLE       | arbitrate TX (tx_valid && Tx_Done) against RX (Rx_Ready)
   // TX_ACC     | tx_ready high, wait for client byte
   // TX_PUT     | write byte to Tx_Buff
   // TX_GO      | write Tx_Enable to Tx_SC
   // RX_STAT    | read Rx_SC
   // RX_STATC   | capture status, drop on error bits
   // RX_LEN     | read Rx_Len
   // RX_LENC    | capture length, drop on zero
   // RX_RD      | read Rx_Buff
   // RX_CAP     | capture received byte
   // RX_OUT     | present byte to consumer until rx_ready
   // RX_DROP    | write Rx_Drop to Rx_SC, pulse rx_err

   localparam int CNT_W = $clog2(MAX_TX_BYTES + 1);

`ifdef HDLC_SCHED_FCS_EN
   localparam sched_state_t RESET_ST = ST_INIT;
   localparam logic [7:0]   DROP_VAL = RX_DROP | RX_FCSEN;
`else
   localparam sched_state_t RESET_ST = ST_IDLE;
   localparam logic [7:0]   DROP_VAL = RX_DROP;
`endif

   sched_state_t      state, nxt;
   logic              gnt_tx, gnt_rx;
   logic [CNT_W-1:0]  tx_left;
   logic              last_q, trunc_q;
   logic [DATA_W-1:0] rx_rem;
   logic              we_d, re_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] din_d;

   hdlc_rr_arbiter u_arb (
      .clk_sys (Clk),
      .rst_b   (Rst),
      .en      (state == ST_IDLE),
      .req_tx  (tx_valid && Tx_Done),
      .req_rx  (Rx_Ready),
      .gnt_tx  (gnt_tx),
      .gnt_rx  (gnt_rx)
   );

   always_comb begin
      nxt = state;
      case (state)
`ifdef HDLC_SCHED_FCS_EN
         ST_INIT:     nxt = ST_IDLE;
`endif
         ST_IDLE: begin
            if (gnt_tx)      nxt = ST_TX_ACC;
            else if (gnt_rx) nxt = ST_RX_STAT;
         end
         ST_TX_ACC:   if (tx_valid) nxt = ST_TX_PUT;
         ST_TX_PUT:   nxt = (last_q || tx_left == CNT_W'(1)) ? ST_TX_GO : ST_TX_ACC;
         ST_TX_GO:    nxt = ST_IDLE;
         ST_RX_STAT:  nxt = ST_RX_STATC;
         ST_RX_STATC: nxt = ((DataOut & DATA_W'(RX_ERR_MASK)) != '0) ? ST_RX_DROP : ST_RX_LEN;
         ST_RX_LEN:   nxt = ST_RX_LENC;
         ST_RX_LENC:  nxt = (DataOut == '0) ? ST_RX_DROP : ST_RX_RD;
         ST_RX_RD:    nxt = ST_RX_CAP;
         ST_RX_CAP:   nxt = ST_RX_OUT;
         ST_RX_OUT: begin
            if (rx_ready) nxt = (rx_rem == DATA_W'(1)) ? ST_IDLE : ST_RX_RD;
         end
         ST_RX_DROP:  nxt = ST_IDLE;
         default:     nxt = ST_IDLE;
      endcase
   end

   // bus strobes are registered from the state being entered, so they coincide with that state
   always_comb begin
      we_d   = 1'b0;
      re_d   = 1'b0;
      addr_d = Address;
      din_d  = '0;
      case (nxt)
         ST_TX_PUT:  begin we_d = 1'b1; addr_d = ADDR_W'(ADDR_TX_BUFF); din_d = tx_data; end
         ST_TX_GO:   begin we_d = 1'b1; addr_d = ADDR_W'(ADDR_TX_SC);   din_d = DATA_W'(TX_ENABLE); end
         ST_RX_STAT: begin re_d = 1'b1; addr_d = ADDR_W'(ADDR_RX_SC); end
         ST_RX_LEN:  begin re_d = 1'b1; addr_d = ADDR_W'(ADDR_RX_LEN); end
         ST_RX_RD:   begin re_d = 1'b1; addr_d = ADDR_W'(ADDR_RX_BUFF); end
         ST_RX_DROP: begin we_d = 1'b1; addr_d = ADDR_W'(ADDR_RX_SC);   din_d = DATA_W'(DROP_VAL); end
         default: ;
      endcase
`ifdef HDLC_SCHED_FCS_EN
      if (state == ST_INIT) begin
         we_d   = 1'b1;
         addr_d = ADDR_W'(ADDR_RX_SC);
         din_d  = DATA_W'(RX_FCSEN);
      end
`endif
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state       <= RESET_ST;
         Address     <= '0;
         WriteEnable <= 1'b0;
         ReadEnable  <= 1'b0;
         DataIn      <= '0;
         tx_left     <= '0;
         last_q      <= 1'b0;
         trunc_q     <= 1'b0;
         rx_rem      <= '0;
         rx_data     <= '0;
         rx_status   <= '0;
      end else begin
         state       <= nxt;
         Address     <= addr_d;
         WriteEnable <= we_d;
         ReadEnable  <= re_d;
         DataIn      <= din_d;
         case (state)
            ST_IDLE: begin
               if (gnt_tx) begin
                  tx_left <= CNT_W'(MAX_TX_BYTES);
                  trunc_q <= 1'b0;
               end
            end
            ST_TX_ACC: if (tx_valid) last_q <= tx_last;
            ST_TX_PUT: begin
               tx_left <= tx_left - CNT_W'(1);
               if (tx_left == CNT_W'(1) && !last_q) trunc_q <= 1'b1;
            end
            ST_RX_STATC: rx_status <= DataOut;
            ST_RX_LENC:  rx_rem    <= DataOut;
            ST_RX_CAP:   rx_data   <= DataOut;
            ST_RX_OUT:   if (rx_ready) rx_rem <= rx_rem - DATA_W'(1);
            default: ;
         endcase
      end
   end

   assign tx_ready = (state == ST_TX_ACC);
   assign tx_trunc = (state == ST_TX_GO) && trunc_q;
   assign rx_valid = (state == ST_RX_OUT);
   assign rx_last  = rx_valid && (rx_rem == DATA_W'(1));
   assign rx_err   = (state == ST_RX_DROP);

endmodule

// File: tb/tb_hdlc_bus_scheduler.sv
// Scoreboard bench for hdlc_bus_scheduler with a small Hdlc register model.
// Honours HDLC_SCHED_FCS_EN (INIT write and FCSen-preserving drop value).
module tb_hdlc_bus_scheduler;

   typedef struct packed {
      logic       wr;
      logic [2:0] addr;
      logic [7:0] data;
   } bus_t;

`ifdef HDLC_SCHED_FCS_EN
   localparam logic [7:0] DROP_VAL = 8'h22;
`else
   localparam logic [7:0] DROP_VAL = 8'h02;
`endif

   logic       Clk, Rst;
   logic [2:0] Address;
   logic       WriteEnable, ReadEnable;
   logic [7:0] DataIn, DataOut;
   logic       Rx_Ready, Tx_Done;
   logic       tx_valid, tx_last, tx_ready, tx_trunc;
   logic [7:0] tx_data;
   logic       rx_valid, rx_last, rx_ready, rx_err;
   logic [7:0] rx_data, rx_status;

   hdlc_bus_scheduler dut (
      .Clk(Clk), .Rst(Rst), .Address(Address), .WriteEnable(WriteEnable),
      .ReadEnable(ReadEnable), .DataIn(DataIn), .DataOut(DataOut),
      .Rx_Ready(Rx_Ready), .Tx_Done(Tx_Done), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
      .tx_trunc(tx_trunc), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_last(rx_last), .rx_ready(rx_ready), .rx_err(rx_err),
      .rx_status(rx_status)
   );

   int vectors = 0;
   int miscompares = 0;
   bus_t       bus_q[$];
   logic [8:0] rx_q[$];
   logic [7:0] err_q[$];
   int trunc_cnt = 0;
   int txr_cnt = 0;
   int posted = 0;
   int taken = 0;
   int busy = 0;
   logic [7:0] m_status, m_len;
   logic [7:0] m_buf [0:3];
   int rd_idx = 0;

   assign Rx_Ready = (posted != taken);
   assign Tx_Done  = (busy == 0);

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
      bus_q.push_back('{wr: 1'b1, addr: a, data: d});
   endtask

   task automatic push_rd(input logic [2:0] a);
      bus_q.push_back('{wr: 1'b0, addr: a, data: 8'h00});
   endtask

   // expected Hdlc accesses for one received frame, then raise Rx_Ready
   task automatic post_rx(input logic [7:0] st, input logic [7:0] len,
                          input logic [7:0] b0, input logic [7:0] b1);
      m_status = st; m_len = len; m_buf[0] = b0; m_buf[1] = b1;
      push_rd(3'd2);
      if ((st & 8'h1C) != 8'h00) begin
         push_wr(3'd2, DROP_VAL);
         err_q.push_back(st);
      end else if (len == 8'd0) begin
         push_rd(3'd4);
         push_wr(3'd2, DROP_VAL);
         err_q.push_back(st);
      end else begin
         push_rd(3'd4);
         for (int i = 0; i < int'(len); i++) begin
            push_rd(3'd3);
            rx_q.push_back({i == int'(len) - 1, (i == 0) ? b0 : b1});
         end
      end
      posted++;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int n = 0;
      tx_valid = 1'b1; tx_data = d; tx_last = l;
      @(negedge Clk);
      while (!tx_ready && n < 500) begin @(negedge Clk); n++; end
      if (n >= 500) chk("tx_handshake_timeout", n, 0);
      @(posedge Clk); #1;
      tx_valid = 1'b0; tx_last = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((bus_q.size() != 0 || rx_q.size() != 0 || err_q.size() != 0 || !Tx_Done) && n < 3000) begin
         @(posedge Clk); n++;
      end
      chk(name, bus_q.size() + rx_q.size() + err_q.size(), 0);
      repeat (4) @(posedge Clk);
      #1;
   endtask

   initial begin
      int c0;
      logic [7:0] tbl_st  [0:2] = '{8'h08, 8'h10, 8'h21};
      logic [7:0] tbl_len [0:2] = '{8'd1, 8'd1, 8'd1};
      Rst = 1'b0; DataOut = 8'h00; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
      rx_ready = 1'b1; m_status = 8'h00; m_len = 8'h00;
      for (int i = 0; i < 4; i++) m_buf[i] = 8'h00;

      fork
         begin : monitor
            bus_t e;
            logic [8:0] r;
            logic pv = 1'b0, pa = 1'b0;
            logic [8:0] pd = '0;
            forever begin
               @(negedge Clk);
               if (Rst) begin
                  if (WriteEnable || ReadEnable) begin
                     if (bus_q.size() == 0)
                        chk("bus_unexpected", {WriteEnable, ReadEnable, Address, DataIn}, 0);
                     else begin
                        e = bus_q.pop_front();
                        chk("bus_access", {WriteEnable, ReadEnable, Address, DataIn},
                            {e.wr, !e.wr, e.addr, e.data});
                     end
                  end else if (DataIn != 8'h00)
                     chk("datain_idle", DataIn, 0);
                  if (rx_valid && pv && !pa) chk("rx_hold", {rx_last, rx_data}, pd);
                  if (rx_valid && rx_ready) begin
                     if (rx_q.size() == 0) chk("rx_unexpected", {rx_last, rx_data}, 0);
                     else begin
                        r = rx_q.pop_front();
                        chk("rx_byte", {rx_last, rx_data}, r);
                     end
                  end
                  if (rx_err) begin
                     if (err_q.size() == 0) chk("rx_err_unexpected", rx_status, 0);
                     else chk("rx_err_status", rx_status, err_q.pop_front());
                  end
                  if (tx_trunc) trunc_cnt++;
                  if (tx_ready) txr_cnt++;
                  pv = rx_valid; pa = rx_ready; pd = {rx_last, rx_data};
               end else
                  pv = 1'b0;
            end
         end
         begin : hdlc_model
            forever begin
               @(negedge Clk);
               if (busy > 0) busy--;
               if (Rst && WriteEnable && Address == 3'd0) busy = 8;
               if (Rst && ReadEnable) begin
                  case (Address)
                     3'd2: begin DataOut = m_status; rd_idx = 0; taken++; end
                     3'd4: DataOut = m_len;
                     3'd3: begin DataOut = m_buf[rd_idx[1:0]]; rd_idx++; end
                     default: DataOut = 8'h00;
                  endcase
               end
            end
         end
      join_none

      #15;
      chk("reset_outputs", {Address, WriteEnable, ReadEnable, DataIn, tx_ready, tx_trunc,
                            rx_valid, rx_data, rx_last, rx_err, rx_status}, 0);
`ifdef HDLC_SCHED_FCS_EN
      push_wr(3'd2, 8'h20);
`endif
      @(posedge Clk); #1; Rst = 1'b1;
      repeat (3) @(posedge Clk); #1;

      // three-byte TX frame
      c0 = txr_cnt;
      push_wr(3'd1, 8'hA5); push_wr(3'd1, 8'h0F); push_wr(3'd1, 8'h7E); push_wr(3'd0, 8'h02);
      send_byte(8'hA5, 1'b0); send_byte(8'h0F, 1'b0); send_byte(8'h7E, 1'b1);
      wait_idle("drain_tx3");
      chk("tx_ready_cycles", txr_cnt - c0, 3);
      chk("tx3_no_trunc", trunc_cnt, 0);

      // 130 bytes, tx_last only on the final one: cut at 126, rest is a second frame
      for (int i = 0; i < 126; i++) push_wr(3'd1, 8'(i));
      push_wr(3'd0, 8'h02);
      for (int i = 126; i < 130; i++) push_wr(3'd1, 8'(i));
      push_wr(3'd0, 8'h02);
      for (int i = 0; i < 130; i++) send_byte(8'(i), i == 129);
      wait_idle("drain_tx130");
      chk("tx_trunc_pulses", trunc_cnt, 1);

      // RX frame with consumer stall
      rx_ready = 1'b0;
      post_rx(8'h01, 8'd2, 8'h11, 8'h22);
      c0 = 0;
      @(negedge Clk);
      while (!rx_valid && c0 < 100) begin @(negedge Clk); c0++; end
      for (int i = 0; i < 5; i++) begin
         chk("rx_stall_valid_data", {rx_valid, rx_last, rx_data}, {1'b1, 1'b0, 8'h11});
         @(negedge Clk);
      end
      @(posedge Clk); #1; rx_ready = 1'b1;
      wait_idle("drain_rx_stall");

      // FrameError drop
      post_rx(8'h05, 8'd2, 8'hEE, 8'hEE);
      wait_idle("drain_rx_frame_error");
      chk("rx_status_after_drop", rx_status, 8'h05);

      // zero length treated as error
      post_rx(8'h00, 8'd0, 8'hEE, 8'hEE);
      wait_idle("drain_rx_len0");

      // Abort, Overflow drop; FCSen/Rx_Drop bits alone are not errors
      for (int i = 0; i < 3; i++) begin
         post_rx(tbl_st[i], tbl_len[i], 8'h5A + 8'(i), 8'h00);
         wait_idle("drain_rx_table");
      end

      // reset during TX_PUT of byte 2
      push_wr(3'd1, 8'hC1);
      send_byte(8'hC1, 1'b0);
      send_byte(8'hC2, 1'b0);
      Rst = 1'b0;
      #1;
      chk("abort_outputs", {Address, WriteEnable, ReadEnable, DataIn, tx_ready, tx_trunc,
                            rx_valid, rx_last, rx_err, rx_status}, 0);
`ifdef HDLC_SCHED_FCS_EN
      push_wr(3'd2, 8'h20);
`endif
      repeat (3) @(posedge Clk); #1; Rst = 1'b1;
      wait_idle("drain_after_abort");

      // simultaneous requests after reset: TX first, then RX
      push_wr(3'd1, 8'h33); push_wr(3'd0, 8'h02);
      post_rx(8'h00, 8'd1, 8'h44, 8'h00);
      send_byte(8'h33, 1'b1);
      wait_idle("drain_tie1");

      push_wr(3'd1, 8'h55); push_wr(3'd0, 8'h02);
      send_byte(8'h55, 1'b1);
      wait_idle("drain_tx_only");

      // TX granted last: the next tie goes to RX
      post_rx(8'h00, 8'd1, 8'h66, 8'h00);
      push_wr(3'd1, 8'h77); push_wr(3'd0, 8'h02);
      send_byte(8'h77, 1'b1);
      wait_idle("drain_tie2");

      chk("final_trunc_pulses", trunc_cnt, 1);
      chk("final_rx_drained", posted - taken, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
